// File: rtl/mux_scan_sequencer_if.sv
// Bus between the mux scan sequencer and its surroundings: the scan request,
// the mux feedback and the select / result outputs.
//
// Optional feature macro: SCAN_CONTINUOUS_EN (adds the cont input).
//
//   start  scan request, sampled only while idle
//   y_in   mux output y fed back from the 4-to-1 mux
//   cont   (SCAN_CONTINUOUS_EN only) restart immediately after a completed scan
//   s1     mux select MSB (channel bit 1)
//   s2     mux select LSB (channel bit 0)
//   busy   scan in progress
//   data   last completed scan, data[k] = y sampled on channel k
//   valid  one-cycle pulse when data is updated
//
// Modports: slave = the sequencer, master = the requester/mux side.
interface mux_scan_sequencer_if;
    logic       start;
    logic       y_in;
`ifdef SCAN_CONTINUOUS_EN
    logic       cont;
`endif
    logic       s1;
    logic       s2;
    logic       busy;
    logic [3:0] data;
    logic       valid;

`ifdef SCAN_CONTINUOUS_EN
    modport slave  (input  start, y_in, cont, output s1, s2, busy, data, valid);
    modport master (output start, y_in, cont, input  s1, s2, busy, data, valid);
`else
    modport slave  (input  start, y_in, output s1, s2, busy, data, valid);
    modport master (output start, y_in, input  s1, s2, busy, data, valid);
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: on a start request, steps the 4-to-1 mux selects
// through channels 0..3, holding each for DWELL cycles, samples the fed-back
// mux output on the last dwell cycle of each channel and publishes the four
// samples as a 4-bit word with a one-cycle valid pulse.
//
// Optional feature macro: SCAN_CONTINUOUS_EN -- when defined, bus.cont=1 on
// the completing edge restarts the scan at channel 0 without an idle cycle.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    mux_scan_sequencer_if.slave (start, y_in, [cont], s1, s2, busy,
//          data, valid)
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | selects parked at 00, busy low, waiting for start
// SCAN  | selects = channel, dwell counter running, sampling y_in
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_scan_sequencer_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       chan_q, chan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [3:0]       data_q, data_d;
    logic             valid_q, valid_d;

    logic             last_dwell;
    logic             restart;

    assign last_dwell = (cnt_q == CNT_LAST);

`ifdef SCAN_CONTINUOUS_EN
    assign restart = bus.cont;
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            chan_q   <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= 3'b000;
            data_q   <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    chan_d  = 2'd0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (last_dwell) begin
                    cnt_d = '0;
                    case (chan_q)
                        2'd0: shadow_d[0] = bus.y_in;
                        2'd1: shadow_d[1] = bus.y_in;
                        2'd2: shadow_d[2] = bus.y_in;
                        default: ;
                    endcase
                    if (chan_q != 2'd3) begin
                        chan_d = chan_q + 2'd1;
                    end else begin
                        // Channel 3 is never shadowed; it goes straight into data.
                        data_d  = {bus.y_in, shadow_q};
                        valid_d = 1'b1;
                        chan_d  = 2'd0;
                        state_d = restart ? SCAN : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == SCAN);
        bus.s1    = (state_q == SCAN) & chan_q[1];
        bus.s2    = (state_q == SCAN) & chan_q[0];
        bus.data  = data_q;
        bus.valid = valid_q;
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;
    localparam int D4 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d4;
    logic [3:0] d1;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer_if if4 ();
    mux_scan_sequencer_if if1 ();

    // Behavioural 4-to-1 mux closing the loop.
    assign if4.y_in = d4[{if4.s1, if4.s2}];
    assign if1.y_in = d1[{if1.s1, if1.s2}];

    mux_scan_sequencer #(.DWELL(D4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .bus(if4));
    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        logic [3:0] d;        // mux data at start
        logic [3:0] d_mid;    // mux data applied after cycle 5 of the scan
        bit         repulse;  // pulse start again during the scan
        logic [3:0] exp;      // expected data word
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full DWELL=4 scan on dut4, checking selects/busy/valid every cycle.
    task automatic run_scan(input vec_t v);
        logic [3:0] exp_flags;
        d4 = v.d;
        @(negedge clk);
        if4.start = 1'b1;
        for (int k = 0; k <= 4 * D4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) if4.start = 1'b0;
            if (v.repulse && k == 4) if4.start = 1'b1;
            if (v.repulse && k == 5) if4.start = 1'b0;
            if (k == 5) d4 = v.d_mid;
            if (k < 4 * D4) begin
                exp_flags = {2'(k / D4), 1'b1, 1'b0};
            end else begin
                exp_flags = 4'b0010 >> 1;  // sel 00, busy 0, valid 1
            end
            check($sformatf("scan k=%0d {s1,s2,busy,valid}", k),
                  {if4.s1, if4.s2, if4.busy, if4.valid}, exp_flags);
        end
        check("scan data", if4.data, v.exp);
        @(posedge clk);
        #1;
        check("valid one cycle", if4.valid, 1'b0);
        check("data held", if4.data, v.exp);
    endtask

    initial begin
        int last_v;
        int n_valid;
        reset     = 1'b1;
        if4.start = 1'b0;
        if1.start = 1'b0;
`ifdef SCAN_CONTINUOUS_EN
        if4.cont  = 1'b0;
        if1.cont  = 1'b0;
`endif
        d4 = 4'b0000;
        d1 = 4'b0000;

        vecs.push_back('{4'b1010, 4'b1010, 1'b0, 4'b1010});  // T1
        vecs.push_back('{4'b1010, 4'b1010, 1'b1, 4'b1010});  // T2
        vecs.push_back('{4'b0101, 4'b0101, 1'b0, 4'b0101});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 4'b1111});
        vecs.push_back('{4'b0011, 4'b0011, 1'b0, 4'b0011});
        vecs.push_back('{4'b1010, 4'b0110, 1'b0, 4'b0110});  // T5
        vecs.push_back('{4'b1100, 4'b1100, 1'b0, 4'b1100});

        repeat (3) @(posedge clk);
        #1;
        check("reset {s1,s2,busy,valid}", {if4.s1, if4.s2, if4.busy, if4.valid}, 4'b0000);
        check("reset data", if4.data, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_scan(vecs[i]);

        // T3: reset between edges mid-scan.
        d4 = 4'b1111;
        @(negedge clk);
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("T3 async reset {s1,s2,busy,valid}",
              {if4.s1, if4.s2, if4.busy, if4.valid}, 4'b0000);
        check("T3 async reset data", if4.data, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        n_valid = 0;
        for (int k = 0; k < 4 * D4 + 4; k++) begin
            @(posedge clk);
            #1;
            if (if4.valid || if4.busy) n_valid++;
        end
        check("T3 no activity after reset", n_valid, 0);

        // T4: DWELL=1, start held high -> valid every 5 cycles.
        d1 = 4'b0101;
        @(negedge clk);
        if1.start = 1'b1;
        last_v  = -1;
        n_valid = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (if1.valid) begin
                if (last_v >= 0) check("T4 valid spacing", c - last_v, 5);
                check("T4 data", if1.data, 4'b0101);
                last_v = c;
                n_valid++;
            end
        end
        if1.start = 1'b0;
        check("T4 valid count >= 5", (n_valid >= 5), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
